projectile_pool: RTL and testbench

PROJECTILE_POOL -- requirements
Module: projectile_pool

---
 rtl/projectile_pkg.sv | 24 ++
 rtl/projectile_slot.sv | 85 ++++++++
 rtl/projectile_pool.sv | 133 +++++++++++++
 tb/tb_projectile_pool.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/projectile_pkg.sv
// Shared defaults, direction encodings and per-slot state encoding
// for the projectile pool and its slot sub-modules.
package projectile_pkg;

    localparam int unsigned DEF_SLOTS    = 12;
    localparam int unsigned DEF_XW       = 7;
    localparam int unsigned DEF_YW       = 6;
    localparam int unsigned DEF_DIR      = 0;
    localparam int unsigned DEF_START_X  = 16;
    localparam int unsigned DEF_HIT_X    = 74;
    localparam int unsigned DEF_STEP     = 2;
    localparam int unsigned DEF_BALL_H   = 8;
    localparam int unsigned DEF_TARGET_H = 20;
    localparam int unsigned DEF_COOLDOWN = 4;

    localparam int unsigned DIR_RIGHT = 0;
    localparam int unsigned DIR_LEFT  = 1;

    typedef enum logic {
        SLOT_IDLE   = 1'b0,
        SLOT_FLIGHT = 1'b1
    } slot_state_t;

endpackage

// File: rtl/projectile_slot.sv
// One projectile slot: spawn, stepwise motion, edge-of-field exit and
// target crossing/overlap detection. Hit/block flags are combinational.
module projectile_slot
    import projectile_pkg::*;
#(
    parameter int unsigned XW       = DEF_XW,
    parameter int unsigned YW       = DEF_YW,
    parameter int unsigned DIR      = DEF_DIR,
    parameter int unsigned START_X  = DEF_START_X,
    parameter int unsigned HIT_X    = DEF_HIT_X,
    parameter int unsigned STEP     = DEF_STEP,
    parameter int unsigned BALL_H   = DEF_BALL_H,
    parameter int unsigned TARGET_H = DEF_TARGET_H
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_spawn,
    input  logic          i_move,
    input  logic [YW-1:0] i_shooter_y,
    input  logic [YW-1:0] i_target_y,
    input  logic          i_target_shield,
    output logic          o_en,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_hit,
    output logic          o_block
);

    localparam logic [XW:0]   STEP_W     = (XW+1)'(STEP);
    localparam logic [XW-1:0] HIT_XW     = XW'(HIT_X);
    localparam logic [XW-1:0] START_XW   = XW'(START_X);
    localparam logic [YW:0]   BALL_HW    = (YW+1)'(BALL_H);
    localparam logic [YW:0]   TARGET_HW  = (YW+1)'(TARGET_H);

    slot_state_t   r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    logic [XW:0]   w_sum;
    logic [XW:0]   w_diff;
    logic          w_exit;
    logic [XW-1:0] w_x_new;
    logic          w_cross;
    logic          w_overlap;
    logic          w_active_move;
    logic          w_strike;

    // The extra MSB of the sum/difference is the carry/borrow that marks leaving the field.
    assign w_sum         = {1'b0, r_x} + STEP_W;
    assign w_diff        = {1'b0, r_x} - STEP_W;
    assign w_exit        = (DIR == DIR_LEFT) ? w_diff[XW] : w_sum[XW];
    assign w_x_new       = (DIR == DIR_LEFT) ? w_diff[XW-1:0] : w_sum[XW-1:0];
    assign w_cross       = (DIR == DIR_LEFT) ? (w_x_new <= HIT_XW) : (w_x_new >= HIT_XW);
    assign w_overlap     = (({1'b0, r_y} + BALL_HW) > {1'b0, i_target_y}) &&
                           ({1'b0, r_y} < ({1'b0, i_target_y} + TARGET_HW));
    assign w_active_move = i_move && (r_state == SLOT_FLIGHT);
    assign w_strike      = w_active_move && !w_exit && w_cross && w_overlap;

    assign o_hit   = w_strike && !i_target_shield;
    assign o_block = w_strike && i_target_shield;
    assign o_en    = (r_state == SLOT_FLIGHT);
    assign o_x     = r_x;
    assign o_y     = r_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SLOT_IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else if (i_spawn && (r_state == SLOT_IDLE)) begin
            r_state <= SLOT_FLIGHT;
            r_x     <= START_XW;
            r_y     <= i_shooter_y;
        end else if (w_active_move) begin
            if (w_exit) begin
                r_state <= SLOT_IDLE;
            end else begin
                r_x <= w_x_new;
                if (w_strike)
                    r_state <= SLOT_IDLE;
            end
        end
    end

endmodule

// File: rtl/projectile_pool.sv
// Projectile pool: shot edge detection, cooldown, lowest-free-slot spawn
// and per-cycle hit/block/drop pulses across SLOTS projectile slots.
module projectile_pool
    import projectile_pkg::*;
#(
    parameter int unsigned SLOTS    = DEF_SLOTS,
    parameter int unsigned XW       = DEF_XW,
    parameter int unsigned YW       = DEF_YW,
    parameter int unsigned DIR      = DEF_DIR,
    parameter int unsigned START_X  = DEF_START_X,
    parameter int unsigned HIT_X    = DEF_HIT_X,
    parameter int unsigned STEP     = DEF_STEP,
    parameter int unsigned BALL_H   = DEF_BALL_H,
    parameter int unsigned TARGET_H = DEF_TARGET_H,
    parameter int unsigned COOLDOWN = DEF_COOLDOWN
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        shoot,
    input  logic                        move_tick,
    input  logic                        freeze,
    input  logic [YW-1:0]               shooter_y,
    input  logic [YW-1:0]               target_y,
    input  logic                        target_shield,
    output logic [SLOTS-1:0]            ball_en,
    output logic [SLOTS*XW-1:0]         ball_x,
    output logic [SLOTS*YW-1:0]         ball_y,
    output logic                        hit,
    output logic [$clog2(SLOTS+1)-1:0]  hit_count,
    output logic                        blocked,
    output logic                        dropped,
    output logic                        pool_full
);

    localparam int unsigned HCW = $clog2(SLOTS+1);
    localparam int unsigned CDW = $clog2(COOLDOWN+2);

    logic           r_shoot_d;
    logic [CDW-1:0] r_cd;
    logic           r_hit;
    logic [HCW-1:0] r_hit_count;
    logic           r_blocked;
    logic           r_dropped;

    logic             w_edge;
    logic             w_accept;
    logic             w_drop;
    logic             w_move;
    logic             w_found;
    logic [SLOTS-1:0] w_free_vec;
    logic [SLOTS-1:0] w_slot_hit;
    logic [SLOTS-1:0] w_slot_block;
    logic [HCW-1:0]   w_hit_sum;

    assign w_edge    = shoot && !r_shoot_d;
    assign pool_full = &ball_en;
    assign w_accept  = w_edge && !freeze && (r_cd == '0) && !pool_full;
    assign w_drop    = w_edge && !freeze && ((r_cd != '0) || pool_full);
    assign w_move    = move_tick && !freeze;

    // Free-slot search uses registered ball_en, so a slot retiring this cycle is not reused until next.
    always_comb begin
        w_free_vec = '0;
        w_found    = 1'b0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!ball_en[i] && !w_found) begin
                w_free_vec[i] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

    always_comb begin
        w_hit_sum = '0;
        for (int unsigned i = 0; i < SLOTS; i++)
            w_hit_sum = w_hit_sum + HCW'(w_slot_hit[i]);
    end

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        projectile_slot #(
            .XW       (XW),
            .YW       (YW),
            .DIR      (DIR),
            .START_X  (START_X),
            .HIT_X    (HIT_X),
            .STEP     (STEP),
            .BALL_H   (BALL_H),
            .TARGET_H (TARGET_H)
        ) u_slot (
            .clk             (clk),
            .reset           (reset),
            .i_spawn         (w_accept && w_free_vec[g]),
            .i_move          (w_move),
            .i_shooter_y     (shooter_y),
            .i_target_y      (target_y),
            .i_target_shield (target_shield),
            .o_en            (ball_en[g]),
            .o_x             (ball_x[g*XW +: XW]),
            .o_y             (ball_y[g*YW +: YW]),
            .o_hit           (w_slot_hit[g]),
            .o_block         (w_slot_block[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shoot_d   <= 1'b0;
            r_cd        <= '0;
            r_hit       <= 1'b0;
            r_hit_count <= '0;
            r_blocked   <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_hit       <= |w_slot_hit;
            r_hit_count <= w_hit_sum;
            r_blocked   <= |w_slot_block;
            r_dropped   <= w_drop;
            if (!freeze) begin
                r_shoot_d <= shoot;
                if (w_accept)
                    r_cd <= CDW'(COOLDOWN);
                else if (move_tick && (r_cd != '0))
                    r_cd <= r_cd - CDW'(1);
            end
        end
    end

    assign hit       = r_hit;
    assign hit_count = r_hit_count;
    assign blocked   = r_blocked;
    assign dropped   = r_dropped;

endmodule

// File: tb/tb_projectile_pool.sv
// Directed testbench for projectile_pool at default parameters.
module tb_projectile_pool;

    logic        clk = 1'b0;
    logic        reset;
    logic        shoot;
    logic        move_tick;
    logic        freeze;
    logic [5:0]  shooter_y;
    logic [5:0]  target_y;
    logic        target_shield;
    logic [11:0] ball_en;
    logic [83:0] ball_x;
    logic [71:0] ball_y;
    logic        hit;
    logic [3:0]  hit_count;
    logic        blocked;
    logic        dropped;
    logic        pool_full;

    int n_checks = 0;
    int n_errors = 0;

    projectile_pool dut (
        .clk           (clk),
        .reset         (reset),
        .shoot         (shoot),
        .move_tick     (move_tick),
        .freeze        (freeze),
        .shooter_y     (shooter_y),
        .target_y      (target_y),
        .target_shield (target_shield),
        .ball_en       (ball_en),
        .ball_x        (ball_x),
        .ball_y        (ball_y),
        .hit           (hit),
        .hit_count     (hit_count),
        .blocked       (blocked),
        .dropped       (dropped),
        .pool_full     (pool_full)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic shot();
        shoot = 1'b1;
        @(negedge clk);
        shoot = 1'b0;
    endtask

    task automatic mtick(input int n);
        for (int i = 0; i < n; i++) begin
            move_tick = 1'b1;
            @(negedge clk);
        end
        move_tick = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (ball_en !== 12'h000) begin n_errors++; $display("FAIL reset_en: got %h want 000", ball_en); end
        n_checks++; if (ball_x !== '0) begin n_errors++; $display("FAIL reset_x: got %h want 0", ball_x); end
        n_checks++; if ({hit, hit_count, blocked, dropped, pool_full} !== 8'h00) begin n_errors++; $display("FAIL reset_flags: got %b want 0", {hit, hit_count, blocked, dropped, pool_full}); end
    endtask

    task automatic test_hit();
        do_reset();
        shooter_y = 6'd10; target_y = 6'd5; target_shield = 1'b0;
        shot();
        n_checks++; if (ball_en !== 12'h001) begin n_errors++; $display("FAIL hit_spawn_en: got %h want 001", ball_en); end
        n_checks++; if (ball_x[6:0] !== 7'd16) begin n_errors++; $display("FAIL hit_spawn_x: got %0d want 16", ball_x[6:0]); end
        n_checks++; if (ball_y[5:0] !== 6'd10) begin n_errors++; $display("FAIL hit_spawn_y: got %0d want 10", ball_y[5:0]); end
        mtick(28);
        n_checks++; if (ball_x[6:0] !== 7'd72 || ball_en !== 12'h001) begin n_errors++; $display("FAIL hit_pre_x: got x=%0d en=%h want 72/001", ball_x[6:0], ball_en); end
        mtick(1);
        n_checks++; if (hit !== 1'b1 || hit_count !== 4'd1) begin n_errors++; $display("FAIL hit_pulse: got hit=%b cnt=%0d want 1/1", hit, hit_count); end
        n_checks++; if (ball_en !== 12'h000 || blocked !== 1'b0) begin n_errors++; $display("FAIL hit_retire: got en=%h blk=%b want 000/0", ball_en, blocked); end
        n_checks++; if (ball_x[6:0] !== 7'd74) begin n_errors++; $display("FAIL hit_x74: got %0d want 74", ball_x[6:0]); end
        @(negedge clk);
        n_checks++; if (hit !== 1'b0 || hit_count !== 4'd0) begin n_errors++; $display("FAIL hit_one_cycle: got hit=%b cnt=%0d want 0/0", hit, hit_count); end
    endtask

    task automatic test_shield();
        do_reset();
        shooter_y = 6'd10; target_y = 6'd5; target_shield = 1'b1;
        shot();
        mtick(29);
        n_checks++; if (blocked !== 1'b1 || hit !== 1'b0 || ball_en !== 12'h000) begin n_errors++; $display("FAIL shield_block: got blk=%b hit=%b en=%h want 1/0/000", blocked, hit, ball_en); end
        @(negedge clk);
        n_checks++; if (blocked !== 1'b0) begin n_errors++; $display("FAIL shield_one_cycle: got %b want 0", blocked); end
        target_shield = 1'b0;
    endtask

    task automatic test_miss_exit();
        do_reset();
        shooter_y = 6'd10; target_y = 6'd40; target_shield = 1'b0;
        shot();
        mtick(29);
        n_checks++; if (ball_en !== 12'h001 || ball_x[6:0] !== 7'd74 || hit !== 1'b0) begin n_errors++; $display("FAIL miss_fly: got en=%h x=%0d hit=%b want 001/74/0", ball_en, ball_x[6:0], hit); end
        mtick(26);
        n_checks++; if (ball_en !== 12'h001 || ball_x[6:0] !== 7'd126) begin n_errors++; $display("FAIL miss_edge: got en=%h x=%0d want 001/126", ball_en, ball_x[6:0]); end
        mtick(1);
        n_checks++; if (ball_en !== 12'h000 || hit !== 1'b0 || blocked !== 1'b0) begin n_errors++; $display("FAIL miss_exit: got en=%h hit=%b blk=%b want 000/0/0", ball_en, hit, blocked); end
    endtask

    task automatic test_fill();
        logic [11:0] exp_en;
        do_reset();
        shooter_y = 6'd10; target_y = 6'd40;
        for (int k = 0; k < 12; k++) begin
            shot();
            exp_en = 12'((1 << (k + 1)) - 1);
            n_checks++; if (ball_en !== exp_en || dropped !== 1'b0) begin n_errors++; $display("FAIL fill_en_%0d: got en=%h drop=%b want %h/0", k, ball_en, dropped, exp_en); end
            mtick(4);
        end
        n_checks++; if (pool_full !== 1'b1) begin n_errors++; $display("FAIL fill_full: got %b want 1", pool_full); end
        n_checks++; if (ball_x[6:0] !== 7'd112 || ball_x[77 +: 7] !== 7'd24) begin n_errors++; $display("FAIL fill_pos: got s0=%0d s11=%0d want 112/24", ball_x[6:0], ball_x[77 +: 7]); end
        shot();
        n_checks++; if (dropped !== 1'b1 || ball_en !== 12'hFFF) begin n_errors++; $display("FAIL fill_drop: got drop=%b en=%h want 1/fff", dropped, ball_en); end
    endtask

    task automatic test_cooldown();
        do_reset();
        shooter_y = 6'd10; target_y = 6'd40;
        shot();
        mtick(2);
        shot();
        n_checks++; if (dropped !== 1'b1 || ball_en !== 12'h001) begin n_errors++; $display("FAIL cd_drop: got drop=%b en=%h want 1/001", dropped, ball_en); end
        @(negedge clk);
        n_checks++; if (dropped !== 1'b0) begin n_errors++; $display("FAIL cd_drop_one_cycle: got %b want 0", dropped); end
        mtick(2);
        shot();
        n_checks++; if (dropped !== 1'b0 || ball_en !== 12'h003) begin n_errors++; $display("FAIL cd_accept: got drop=%b en=%h want 0/003", dropped, ball_en); end
    endtask

    task automatic test_multi_hit();
        do_reset();
        shooter_y = 6'd10; target_y = 6'd40; target_shield = 1'b0;
        shot(); mtick(4);
        shot(); mtick(4);
        shot(); mtick(29);
        n_checks++; if (ball_en !== 12'h007 || hit !== 1'b0) begin n_errors++; $display("FAIL multi_pre: got en=%h hit=%b want 007/0", ball_en, hit); end
        n_checks++; if (ball_x[6:0] !== 7'd90 || ball_x[14 +: 7] !== 7'd74) begin n_errors++; $display("FAIL multi_pos: got s0=%0d s2=%0d want 90/74", ball_x[6:0], ball_x[14 +: 7]); end
        target_y = 6'd5;
        mtick(1);
        n_checks++; if (hit !== 1'b1 || hit_count !== 4'd3 || ball_en !== 12'h000) begin n_errors++; $display("FAIL multi_hit: got hit=%b cnt=%0d en=%h want 1/3/000", hit, hit_count, ball_en); end
        @(negedge clk);
        n_checks++; if (hit !== 1'b0 || hit_count !== 4'd0) begin n_errors++; $display("FAIL multi_one_cycle: got hit=%b cnt=%0d want 0/0", hit, hit_count); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        shooter_y = 6'd10; target_y = 6'd5; target_shield = 1'b0;
        shot();
        mtick(28);
        reset = 1'b1; move_tick = 1'b1;
        @(negedge clk);
        reset = 1'b0; move_tick = 1'b0;
        n_checks++; if (hit !== 1'b0 || ball_en !== 12'h000 || ball_x[6:0] !== 7'd0) begin n_errors++; $display("FAIL rst_mid: got hit=%b en=%h x=%0d want 0/000/0", hit, ball_en, ball_x[6:0]); end
        @(negedge clk);
        n_checks++; if (hit !== 1'b0 || blocked !== 1'b0) begin n_errors++; $display("FAIL rst_mid_after: got hit=%b blk=%b want 0/0", hit, blocked); end
    endtask

    task automatic test_freeze();
        do_reset();
        shooter_y = 6'd10; target_y = 6'd40;
        for (int k = 0; k < 5; k++) begin
            shot(); mtick(4);
        end
        freeze = 1'b1;
        mtick(10);
        shot();
        n_checks++; if (ball_en !== 12'h01F || dropped !== 1'b0) begin n_errors++; $display("FAIL frz_shot: got en=%h drop=%b want 01f/0", ball_en, dropped); end
        n_checks++; if (ball_x[6:0] !== 7'd56 || ball_x[28 +: 7] !== 7'd24) begin n_errors++; $display("FAIL frz_pos: got s0=%0d s4=%0d want 56/24", ball_x[6:0], ball_x[28 +: 7]); end
        @(negedge clk);
        n_checks++; if (dropped !== 1'b0) begin n_errors++; $display("FAIL frz_nodrop: got %b want 0", dropped); end
        do_reset();
        n_checks++; if (ball_en !== 12'h000 || ball_x !== '0 || ball_y !== '0) begin n_errors++; $display("FAIL frz_reset_slots: got en=%h x=%h y=%h want 0", ball_en, ball_x, ball_y); end
        n_checks++; if ({hit, hit_count, blocked, dropped, pool_full} !== 8'h00) begin n_errors++; $display("FAIL frz_reset_flags: got %b want 0", {hit, hit_count, blocked, dropped, pool_full}); end
        freeze = 1'b0;
    endtask

    initial begin
        reset = 1'b1; shoot = 1'b0; move_tick = 1'b0; freeze = 1'b0;
        shooter_y = '0; target_y = '0; target_shield = 1'b0;
        @(negedge clk);
        test_reset();
        test_hit();
        test_shield();
        test_miss_exit();
        test_fill();
        test_cooldown();
        test_multi_hit();
        test_reset_midflight();
        test_freeze();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
